// File: rtl/hcsr04_pkg.sv
// Shared definitions for the HC-SR04 interface control unit: state codes,
// debug bus width and the default number of trigger attempts.
package hcsr04_pkg;

   localparam int DB_ESTADO_W        = 4;
   localparam int MAX_TENTATIVAS_DEF = 3;

   localparam logic [DB_ESTADO_W-1:0] INICIAL  = 4'h0;
   localparam logic [DB_ESTADO_W-1:0] PREPARA  = 4'h1;
   localparam logic [DB_ESTADO_W-1:0] ENVIA    = 4'h2;
   localparam logic [DB_ESTADO_W-1:0] ESPERA   = 4'h3;
   localparam logic [DB_ESTADO_W-1:0] ARMAZENA = 4'h4;
   localparam logic [DB_ESTADO_W-1:0] FINAL    = 4'h5;
   localparam logic [DB_ESTADO_W-1:0] FALHA    = 4'h6;
   localparam logic [DB_ESTADO_W-1:0] ERRO     = 4'hE;

   typedef enum logic [DB_ESTADO_W-1:0] {
      S_INICIAL  = INICIAL,
      S_PREPARA  = PREPARA,
      S_ENVIA    = ENVIA,
      S_ESPERA   = ESPERA,
      S_ARMAZENA = ARMAZENA,
      S_FINAL    = FINAL,
      S_FALHA    = FALHA,
      S_ERRO     = ERRO
   } estado_t;

endpackage

// File: rtl/interface_hcsr04_uc_detector_borda.sv
// Registered rising-edge detector: borda is high in the cycle where sinal is
// high and was low at the previous clock edge.
module detector_borda (
   input  logic clock,
   input  logic reset,
   input  logic sinal,
   output logic borda
);

   logic sinal_q;
   logic sinal_d;

   always_comb begin
      sinal_d = sinal;
   end

   always_ff @(posedge clock) begin
      if (reset) sinal_q <= 1'b0;
      else       sinal_q <= sinal_d;
   end

   assign borda = sinal & ~sinal_q;

endmodule

// File: rtl/interface_hcsr04_uc.sv
// HC-SR04 measurement sequencer (Moore FSM). Define HCSR04_RETRY_EN to retry
// timed-out measurements up to MAX_TENTATIVAS attempts before flagging erro.
//
// state    | meaning
// ---------+-------------------------------------------------
// INICIAL  | idle, waiting for a rising edge on medir
// PREPARA  | clear pulse generator, cm counter, result, timeout
// ENVIA    | fire the trigger pulse (one cycle)
// ESPERA   | run timeout counter, wait for echo or timeout
// ARMAZENA | load distance register
// FINAL    | pronto pulse
// FALHA    | attempt timed out, decide retry or give up
// ERRO     | erro pulse, distance register keeps last value
module interface_hcsr04_uc
   import hcsr04_pkg::*;
#(
   parameter int MAX_TENTATIVAS = MAX_TENTATIVAS_DEF
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   medir,
   input  logic                   fim_medida,
   input  logic                   timeout,
   output logic                   zera,
   output logic                   gera,
   output logic                   zera_timeout,
   output logic                   conta_timeout,
   output logic                   registra,
   output logic                   pronto,
   output logic                   erro,
   output logic [DB_ESTADO_W-1:0] db_estado
);

   if (MAX_TENTATIVAS < 1 || MAX_TENTATIVAS > 15) begin : g_param_check
      $error("interface_hcsr04_uc: MAX_TENTATIVAS must be in 1..15");
   end

   estado_t state_q;
   estado_t state_d;
   logic    medir_borda;
   logic    retry_ok;

   detector_borda u_detector_borda (
      .clock (clock),
      .reset (reset),
      .sinal (medir),
      .borda (medir_borda)
   );

`ifdef HCSR04_RETRY_EN
   localparam int CW = $clog2(MAX_TENTATIVAS + 1);

   logic [CW-1:0] tent_q;
   logic [CW-1:0] tent_d;
   logic [CW-1:0] tent_inc;

   // Saturating increment; the compare uses the incremented value so that
   // MAX_TENTATIVAS counts attempts, not retries.
   always_comb begin
      tent_inc = (tent_q == CW'(MAX_TENTATIVAS)) ? tent_q : tent_q + 1'b1;
      retry_ok = (tent_inc < CW'(MAX_TENTATIVAS));
      tent_d   = tent_q;
      if (state_q == S_INICIAL)    tent_d = '0;
      else if (state_q == S_FALHA) tent_d = tent_inc;
   end

   always_ff @(posedge clock) begin
      if (reset) tent_q <= '0;
      else       tent_q <= tent_d;
   end
`else
   always_comb begin
      retry_ok = 1'b0;
   end
`endif

   always_ff @(posedge clock) begin
      if (reset) state_q <= S_INICIAL;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_INICIAL:  if (medir_borda) state_d = S_PREPARA;
         S_PREPARA:  state_d = S_ENVIA;
         S_ENVIA:    state_d = S_ESPERA;
         // echo beats timeout when both arrive together
         S_ESPERA: begin
            if (fim_medida)   state_d = S_ARMAZENA;
            else if (timeout) state_d = S_FALHA;
         end
         S_ARMAZENA: state_d = S_FINAL;
         S_FINAL:    state_d = S_INICIAL;
         S_FALHA:    state_d = retry_ok ? S_PREPARA : S_ERRO;
         S_ERRO:     state_d = S_INICIAL;
         default:    state_d = S_INICIAL;
      endcase
   end

   always_comb begin
      zera          = 1'b0;
      gera          = 1'b0;
      zera_timeout  = 1'b0;
      conta_timeout = 1'b0;
      registra      = 1'b0;
      pronto        = 1'b0;
      erro          = 1'b0;
      case (state_q)
         S_PREPARA: begin
            zera         = 1'b1;
            zera_timeout = 1'b1;
         end
         S_ENVIA:    gera          = 1'b1;
         S_ESPERA:   conta_timeout = 1'b1;
         S_ARMAZENA: registra      = 1'b1;
         S_FINAL:    pronto        = 1'b1;
         S_ERRO:     erro          = 1'b1;
         default:    ;
      endcase
   end

   assign db_estado = state_q;

endmodule

// File: tb/tb_interface_hcsr04_uc.sv
// Directed bench for interface_hcsr04_uc: per-cycle vector table plus
// multi-cycle sequences for retry, tie-break and medir edge handling.
module tb_interface_hcsr04_uc;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       medir = 1'b0;
   logic       fim_medida = 1'b0;
   logic       timeout = 1'b0;
   logic       zera, gera, zera_timeout, conta_timeout, registra, pronto, erro;
   logic [3:0] db_estado;

   int n_vec = 0;
   int n_err = 0;
   int c_zera, c_gera, c_zt, c_ct, c_reg, c_pronto, c_erro;

`ifdef HCSR04_RETRY_EN
   localparam int N_TENT = 3;
`else
   localparam int N_TENT = 1;
`endif

   interface_hcsr04_uc dut (
      .clock         (clock),
      .reset         (reset),
      .medir         (medir),
      .fim_medida    (fim_medida),
      .timeout       (timeout),
      .zera          (zera),
      .gera          (gera),
      .zera_timeout  (zera_timeout),
      .conta_timeout (conta_timeout),
      .registra      (registra),
      .pronto        (pronto),
      .erro          (erro),
      .db_estado     (db_estado)
   );

   always #10 clock = ~clock;

   typedef struct packed {
      logic       rst;
      logic       m;
      logic       f;
      logic       t;
      logic [3:0] estado;
   } vec_t;

   vec_t tab [0:19];

   // {zera, gera, zera_timeout, conta_timeout, registra, pronto, erro}
   function automatic logic [6:0] saidas_esp(input logic [3:0] e);
      case (e)
         4'h1:    return 7'b1010000;
         4'h2:    return 7'b0100000;
         4'h3:    return 7'b0001000;
         4'h4:    return 7'b0000100;
         4'h5:    return 7'b0000010;
         4'hE:    return 7'b0000001;
         default: return 7'b0000000;
      endcase
   endfunction

   task automatic chk(input string nome, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nome, act, exp);
      end
   endtask

   task automatic zera_cont();
      c_zera = 0; c_gera = 0; c_zt = 0; c_ct = 0;
      c_reg = 0; c_pronto = 0; c_erro = 0;
   endtask

   task automatic ciclo(input logic r, input logic m, input logic f, input logic t);
      reset = r; medir = m; fim_medida = f; timeout = t;
      @(posedge clock);
      #1;
      c_zera   += int'(zera);
      c_gera   += int'(gera);
      c_zt     += int'(zera_timeout);
      c_ct     += int'(conta_timeout);
      c_reg    += int'(registra);
      c_pronto += int'(pronto);
      c_erro   += int'(erro);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      tab[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0};
      tab[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0};
      tab[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h1};
      tab[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h2};
      tab[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h3};
      tab[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h3};
      tab[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 4'h4};
      tab[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h5};
      tab[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0};
      tab[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h1};
      tab[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h2};
      tab[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h3};
      tab[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0};
      tab[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h1};
      tab[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h2};
      tab[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h3};
      tab[16] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'h4};
      tab[17] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h5};
      tab[18] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h0};
      tab[19] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h0};

      zera_cont();
      for (int i = 0; i < 20; i++) begin
         ciclo(tab[i].rst, tab[i].m, tab[i].f, tab[i].t);
         chk($sformatf("vec%0d db_estado", i), int'(db_estado), int'(tab[i].estado));
         chk($sformatf("vec%0d saidas", i),
             int'({zera, gera, zera_timeout, conta_timeout, registra, pronto, erro}),
             int'(saidas_esp(tab[i].estado)));
      end

      // echo 100 cycles after ENVIA
      ciclo(0, 0, 0, 0);
      zera_cont();
      ciclo(0, 1, 0, 0);
      chk("a_prepara", int'(db_estado), 1);
      ciclo(0, 0, 0, 0);
      chk("a_envia", int'(db_estado), 2);
      for (int i = 0; i < 100; i++) ciclo(0, 0, 0, 0);
      chk("a_espera", int'(db_estado), 3);
      ciclo(0, 0, 1, 0);
      chk("a_registra_k1", int'(registra), 1);
      ciclo(0, 0, 0, 0);
      chk("a_pronto_k2", int'(pronto), 1);
      ciclo(0, 0, 0, 0);
      chk("a_inicial_k3", int'(db_estado), 0);
      chk("a_gera_count", c_gera, 1);
      chk("a_ct_count", c_ct, 100);
      chk("a_pronto_count", c_pronto, 1);
      chk("a_erro_count", c_erro, 0);

      // timeout on every attempt
      ciclo(0, 0, 0, 0);
      zera_cont();
      ciclo(0, 1, 0, 1);
      for (int i = 0; i < 30; i++) ciclo(0, 0, 0, 1);
      chk("b_gera_count", c_gera, N_TENT);
      chk("b_zera_timeout_count", c_zt, N_TENT);
      chk("b_zera_count", c_zera, N_TENT);
      chk("b_erro_count", c_erro, 1);
      chk("b_pronto_count", c_pronto, 0);
      chk("b_db_final", int'(db_estado), 0);

      // timeout on attempt 1, echo on attempt 2
      ciclo(0, 0, 0, 0);
      zera_cont();
      ciclo(0, 1, 0, 0);
      ciclo(0, 0, 0, 0);
      ciclo(0, 0, 0, 0);
      ciclo(0, 0, 0, 1);
      chk("c_falha", int'(db_estado), 6);
      ciclo(0, 0, 0, 0);
`ifdef HCSR04_RETRY_EN
      chk("c_retry_prepara", int'(db_estado), 1);
      ciclo(0, 0, 0, 0);
      ciclo(0, 0, 0, 0);
      chk("c_espera2", int'(db_estado), 3);
      ciclo(0, 0, 1, 0);
      ciclo(0, 0, 0, 0);
      ciclo(0, 0, 0, 0);
      chk("c_pronto_count", c_pronto, 1);
      chk("c_erro_count", c_erro, 0);
      chk("c_gera_count", c_gera, 2);
`else
      chk("c_erro_state", int'(db_estado), 14);
      ciclo(0, 0, 0, 0);
      chk("c_pronto_count", c_pronto, 0);
      chk("c_erro_count", c_erro, 1);
      chk("c_gera_count", c_gera, 1);
`endif
      chk("c_db_final", int'(db_estado), 0);

      // medir held high for 1000 cycles with echo always present
      ciclo(0, 0, 0, 0);
      zera_cont();
      for (int i = 0; i < 1000; i++) ciclo(0, 1, 1, 0);
      chk("d_held_pronto_count", c_pronto, 1);
      chk("d_held_gera_count", c_gera, 1);
      chk("d_held_db", int'(db_estado), 0);

      // second rising edge during ESPERA must be dropped
      ciclo(0, 0, 0, 0);
      zera_cont();
      ciclo(0, 1, 0, 0);
      ciclo(0, 0, 0, 0);
      ciclo(0, 0, 0, 0);
      ciclo(0, 1, 0, 0);
      chk("d_edge_in_espera", int'(db_estado), 3);
      ciclo(0, 1, 1, 0);
      ciclo(0, 1, 0, 0);
      ciclo(0, 1, 0, 0);
      for (int i = 0; i < 10; i++) ciclo(0, 1, 0, 0);
      chk("d_no_queued_db", int'(db_estado), 0);
      chk("d_no_queued_pronto", c_pronto, 1);
      chk("d_no_queued_gera", c_gera, 1);

      // reset mid-measurement from ESPERA
      ciclo(0, 0, 0, 0);
      ciclo(0, 1, 0, 0);
      ciclo(0, 0, 0, 0);
      ciclo(0, 0, 0, 0);
      chk("e_ct_before_reset", int'(conta_timeout), 1);
      ciclo(1, 0, 0, 0);
      chk("e_db_after_reset", int'(db_estado), 0);
      chk("e_outs_after_reset",
          int'({zera, gera, zera_timeout, conta_timeout, registra, pronto, erro}), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/interface_hcsr04_uc.md
# interface_hcsr04_uc

Control unit that sequences the HC-SR04 ultrasonic interface datapath through one measurement cycle. It clears the datapath, fires the 10 µs trigger, supervises the echo with the datapath timeout counter, and latches the distance. On timeout it optionally retries before flagging an error. It sits beside `interface_hcsr04_fd` inside the interface top and drives all of that datapath's control inputs.

## Interface
- `MAX_TENTATIVAS`, default 3: number of trigger attempts per request before `erro`; legal range 1..15.
- `clock` in 1: system clock, 50 MHz.
- `reset` in 1: synchronous, active-high.
- `medir` in 1: measurement request, level input; a rising edge starts a cycle.
- `fim_medida` in 1: datapath status, echo measured.
- `timeout` in 1: datapath status, timeout counter expired.
- `zera` out 1: clears the pulse generator, the cm counter and the result register.
- `gera` out 1: starts the trigger pulse.
- `zera_timeout` out 1: clears the timeout counter.
- `conta_timeout` out 1: enables the timeout counter.
- `registra` out 1: loads the distance register.
- `pronto` out 1: one-cycle pulse, new distance valid.
- `erro` out 1: one-cycle pulse, all attempts timed out.
- `db_estado` out 4: current state code, for debug/7-seg.

## Operation
- Moore FSM; every output decodes from state only. Codes:
  - INICIAL 0x0: all outputs 0. On `medir` rising edge, go to PREPARA; attempt counter is cleared.
  - PREPARA 0x1: `zera`=1, `zera_timeout`=1. Next state is ENVIA.
  - ENVIA 0x2: `gera`=1 for exactly one cycle. Next state is ESPERA.
  - ESPERA 0x3: `conta_timeout`=1.
    - If `fim_medida`, go to ARMAZENA.
    - Else if `timeout`, go to FALHA.
    - Else stay.
  - ARMAZENA 0x4: `registra`=1. Next state is FINAL.
  - FINAL 0x5: `pronto`=1. Next state is INICIAL.
  - FALHA 0x6: the attempt counter increments. If the incremented count is below `MAX_TENTATIVAS`, go to PREPARA; else go to ERRO.
  - ERRO 0xE: `erro`=1, then go to INICIAL. The distance register keeps its last value.
- Unused codes go to INICIAL on the next clock.
- `fim_medida` and `timeout` asserted in the same cycle: `fim_medida` wins.
- `medir` is edge-detected. Holding it high yields one cycle only. Edges outside INICIAL are ignored and not queued.
- The attempt counter is `$clog2(MAX_TENTATIVAS+1)` bits. It is cleared on reset and on leaving INICIAL, and it saturates with no wrap.

## Timing
- Reset, at any state including mid-measurement: next edge gives INICIAL, all outputs 0, `db_estado`=0, counter 0, edge-detector history 0.
- `medir` rises and is sampled at edge 0: PREPARA after edge 0, ENVIA after edge 1, ESPERA after edge 2.
- `fim_medida` sampled high at edge k in ESPERA: `registra` during cycle k+1, `pronto` during k+2, INICIAL at k+3.
- Timeout sampled at edge k: FALHA during k+1, then PREPARA (retry) or ERRO during k+2.
- Fixed overhead from request to ESPERA is 3 cycles, plus 3 cycles per retry.

## Configuration
- `HCSR04_RETRY_EN` defined: retry behaviour as above, with `MAX_TENTATIVAS` attempts.
- Not defined: FALHA always goes to ERRO, so there is a single attempt. The attempt counter is not synthesized and `MAX_TENTATIVAS` is ignored. All other timing is unchanged.

## Structure
- Package `hcsr04_pkg` holds:
  - the state encodings (localparams INICIAL…ERRO);
  - the `MAX_TENTATIVAS` default;
  - the `db_estado` width.
- One sub-module, `detector_borda`: a 1-bit registered rising-edge detector with synchronous active-high `reset`, used on `medir`.

## Test plan
- Reset in ESPERA (`conta_timeout`=1): next cycle all outputs 0, `db_estado`=0x0.
- `medir` pulse, then `fim_medida` 100 cycles after ENVIA:
  - `gera` high exactly 1 cycle;
  - `registra` at k+1 and `pronto` at k+2;
  - `erro` never high.
- `HCSR04_RETRY_EN`, `MAX_TENTATIVAS`=3, `timeout` every attempt: 3 `gera` pulses, 3 `zera_timeout` pulses, then `erro` 1 cycle, then `db_estado` returns to 0x0. Without the macro: 1 `gera`, then `erro`.
- Timeout on attempt 1, `fim_medida` on attempt 2: `pronto` once, `erro` never.
- `fim_medida` and `timeout` in the same cycle: ARMAZENA taken and `pronto` asserted.
- `medir` held high 1000 cycles across a complete measurement: exactly one `pronto`. A second rising edge raised during ESPERA produces no extra cycle.
